msg_checker: RTL

MSG_CHECKER -- requirements
Module: msg_checker

---
 rtl/msg_pkg.sv | 18 +
 rtl/msg_rom.sv | 14 +
 rtl/msg_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared constants and state type for the message checker
package msg_pkg;

   localparam int MSG_LEN_DEFAULT = 13;

   // "hello world!\n", index 0 is the first byte on the wire
   localparam logic [7:0] EXP_MSG [MSG_LEN_DEFAULT] = '{
      8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77,
      8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a
   };

   typedef enum logic [1:0] {
      HUNT,
      CHECK,
      SKIP
   } state_t;

endpackage

// File: rtl/msg_rom.sv
// rtl/msg_rom.sv - combinational lookup of the expected byte at a message position
module msg_rom
   import msg_pkg::*;
(
   input  logic [3:0] pos,
   output logic [7:0] value
);

   always_comb begin
      value = 8'h00;
      if (int'(pos) < MSG_LEN_DEFAULT) value = EXP_MSG[pos];
   end

endmodule

// File: rtl/msg_checker.sv
// rtl/msg_checker.sv - lock/error tracker for a repeating "hello world!\n" byte stream
// Statistics counters are built only when MSG_CHECKER_STATS_EN is defined.
module msg_checker
   import msg_pkg::*;
#(
   parameter int MSG_LEN     = MSG_LEN_DEFAULT,
   parameter int GAP_LEN     = 1,
   parameter int LOCK_FRAMES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       data,
   input  logic             valid,
   output logic             locked,
   output logic             frame_ok,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] error_count
);

   localparam logic [3:0] POS_LAST   = 4'(MSG_LEN - 1);
   localparam logic [3:0] GAP_LAST   = 4'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
   localparam logic [3:0] LOCK_N     = 4'(LOCK_FRAMES);
   localparam logic [7:0] START_BYTE = EXP_MSG[0];

   state_t     state;
   logic [3:0] pos;
   logic [3:0] gap;
   logic [3:0] run;
   logic [3:0] run_next;
   logic [7:0] exp_byte;
   logic       match;
   logic       good_frame;
   logic       mismatch;

   msg_rom u_rom (
      .pos   (pos),
      .value (exp_byte)
   );

   assign match      = (data == exp_byte);
   assign good_frame = valid && (state == CHECK) && match && (pos == POS_LAST);
   assign mismatch   = valid && (state == CHECK) && !match;
   assign run_next   = (run == LOCK_N) ? run : run + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         pos      <= '0;
         gap      <= '0;
         run      <= '0;
         locked   <= 1'b0;
         frame_ok <= 1'b0;
      end else begin
         frame_ok <= 1'b0;
         if (valid) begin
            case (state)
               HUNT: begin
                  if (data == START_BYTE) begin
                     state <= CHECK;
                     pos   <= 4'd1;
                  end
               end
               CHECK: begin
                  if (good_frame) begin
                     frame_ok <= 1'b1;
                     run      <= run_next;
                     if (run_next == LOCK_N) locked <= 1'b1;
                     pos      <= '0;
                     gap      <= '0;
                     if (GAP_LEN != 0) state <= SKIP;
                  end else if (match) begin
                     pos <= pos + 4'd1;
                  end else begin
                     run    <= '0;
                     locked <= 1'b0;
                     // a stray start byte restarts the frame instead of being lost
                     if (data == START_BYTE) begin
                        state <= CHECK;
                        pos   <= 4'd1;
                     end else begin
                        state <= HUNT;
                        pos   <= '0;
                     end
                  end
               end
               default: begin
                  if (gap == GAP_LAST) begin
                     state <= CHECK;
                     pos   <= '0;
                     gap   <= '0;
                  end else begin
                     gap <= gap + 4'd1;
                  end
               end
            endcase
         end
      end
   end

`ifdef MSG_CHECKER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count <= '0;
         error_count <= '0;
      end else begin
         if (good_frame && (frame_count != '1)) frame_count <= frame_count + CNT_W'(1);
         if (mismatch && (error_count != '1)) error_count <= error_count + CNT_W'(1);
      end
   end
`else
   assign frame_count = '0;
   assign error_count = '0;
`endif

endmodule
